// File: rtl/fpu_fmac_pkg.sv
// Shared FMAC definitions: sideband width and the segment geometry helpers
// used to slice the carry-propagate add into pipeline stages.
package fpu_fmac_pkg;

   localparam int TAG_W = 4;

   // Number of SEG-bit segments needed to cover the (n+2)-bit result.
   function automatic int calc_stages(input int n, input int seg);
      return (n + 2 + seg - 1) / seg;
   endfunction

   // Lowest result bit handled by segment k.
   function automatic int seg_lo(input int k, input int seg);
      return k * seg;
   endfunction

   // Width of segment k; the top segment is narrower when (n+2) % seg != 0.
   function automatic int seg_width(input int k, input int n, input int seg);
      int rem;
      rem = n + 2 - k * seg;
      return (rem < seg) ? rem : seg;
   endfunction

endpackage

// File: rtl/csa_resolve_seg.sv
// One elastic pipeline stage of the carry-propagate adder: resolves one
// segment of the operands using the carry registered by the previous stage.
module csa_resolve_seg
   import fpu_fmac_pkg::*;
#(
   parameter int W  = 51,
   parameter int LO = 0,
   parameter int SW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             up_ready,
   input  logic [W-1:0]     a_in,
   input  logic [W-1:0]     b_in,
   input  logic             cin,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             down_ready,
   output logic [W-1:0]     a_out,
   output logic [W-1:0]     b_out,
   output logic             cout,
   output logic [TAG_W-1:0] tag_out
);

   logic [SW-1:0] seg_sum;
   logic          seg_cout;
   logic [W-1:0]  a_next;
   logic [W-1:0]  b_next;

   // A flush must never be blocked, so it forces the stage open.
   assign up_ready = flush | ~out_valid | down_ready;

   // Add this segment; resolved bits replace the A operand bits, B bits are cleared.
   always_comb begin
      {seg_cout, seg_sum} = {1'b0, a_in[LO +: SW]} + {1'b0, b_in[LO +: SW]}
                            + {{SW{1'b0}}, cin};
      a_next           = a_in;
      a_next[LO +: SW] = seg_sum;
      b_next           = b_in;
      b_next[LO +: SW] = '0;
   end

   // Stage occupancy: cleared by reset or flush, otherwise follows upstream when open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (up_ready) begin
         out_valid <= in_valid;
      end
   end

   // Payload registers load only on a real accept so held outputs stay stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_out   <= '0;
         b_out   <= '0;
         cout    <= 1'b0;
         tag_out <= '0;
      end else if (!flush && up_ready && in_valid) begin
         a_out   <= a_next;
         b_out   <= b_next;
         cout    <= seg_cout;
         tag_out <= tag_in;
      end
   end

endmodule

// File: rtl/csa_resolve_pipe.sv
// Pipelined carry-propagate back end: turns a carry-save (sum, carry) pair
// into the exact binary value sum + 2*carry, one segment per stage.
module csa_resolve_pipe
   import fpu_fmac_pkg::*;
#(
   parameter int N   = 49,
   parameter int SEG = 16
) (
   input  logic             Clk_CI,
   input  logic             Rst_RI,
   input  logic             Flush_SI,
   input  logic             InValid_SI,
   output logic             InReady_SO,
   input  logic [N-1:0]     Sum_DI,
   input  logic [N-1:0]     Carry_DI,
   input  logic [TAG_W-1:0] Tag_DI,
   output logic             OutValid_SO,
   input  logic             OutReady_SI,
   output logic [N+1:0]     Result_DO,
   output logic             Zero_SO,
   output logic [TAG_W-1:0] Tag_DO
);

   localparam int W      = N + 2;
   localparam int STAGES = calc_stages(N, SEG);

   logic [W-1:0]     a_s [STAGES+1];
   logic [W-1:0]     b_s [STAGES+1];
   logic [TAG_W-1:0] t_s [STAGES+1];
   logic [STAGES:0]  v_s;
   logic [STAGES:0]  c_s;
   logic [STAGES-1:0] up_rdy;
   logic [STAGES-1:0] down_rdy;
   logic              unused_bits;

   assign a_s[0] = {2'b00, Sum_DI};
   assign b_s[0] = {1'b0, Carry_DI, 1'b0};
   assign t_s[0] = Tag_DI;
   assign v_s[0] = InValid_SI;
   assign c_s[0] = 1'b0;

   // Ready seen by each stage, built back from the consumer without a skid buffer.
   always_comb begin
      down_rdy           = '0;
      down_rdy[STAGES-1] = OutReady_SI;
      for (int k = STAGES - 2; k >= 0; k--) begin
         down_rdy[k] = Flush_SI | ~v_s[k+2] | down_rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = seg_lo(k, SEG);
      localparam int SW = seg_width(k, N, SEG);

      csa_resolve_seg #(
         .W  (W),
         .LO (LO),
         .SW (SW)
      ) u_seg (
         .clk        (Clk_CI),
         .rst        (Rst_RI),
         .flush      (Flush_SI),
         .in_valid   (v_s[k]),
         .up_ready   (up_rdy[k]),
         .a_in       (a_s[k]),
         .b_in       (b_s[k]),
         .cin        (c_s[k]),
         .tag_in     (t_s[k]),
         .out_valid  (v_s[k+1]),
         .down_ready (down_rdy[k]),
         .a_out      (a_s[k+1]),
         .b_out      (b_s[k+1]),
         .cout       (c_s[k+1]),
         .tag_out    (t_s[k+1])
      );
   end

   assign InReady_SO  = up_rdy[0];
   assign OutValid_SO = v_s[STAGES];
   assign Result_DO   = a_s[STAGES];
   assign Tag_DO      = t_s[STAGES];
   assign Zero_SO     = v_s[STAGES] & ~|a_s[STAGES];

   // The fully cleared B vector and the top carry-out (always 0) are not needed.
   assign unused_bits = ^{b_s[STAGES], c_s[STAGES], up_rdy};

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Directed self-checking bench for csa_resolve_pipe: single results,
// segment carries, a stalled stream, flush and mid-stream reset.
module tb_csa_resolve_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        inValid;
   logic        inReady;
   logic [48:0] sumIn;
   logic [48:0] carryIn;
   logic [3:0]  tagIn;
   logic        outValid;
   logic        outReady;
   logic [50:0] result;
   logic        zero;
   logic [3:0]  tagOut;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [48:0] streamSum [8] = '{
      49'h0_0000_0000_FFFF, 49'h1_2345_6789_ABCD, 49'h0_0000_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF,
      49'h0_5555_5555_5555, 49'h0_0001_0000_0000, 49'h0_0000_0000_0000, 49'h0_0F0F_0F0F_0F0F};
   logic [48:0] streamCarry [8] = '{
      49'h0_0000_0000_8000, 49'h0_FEDC_BA98_7654, 49'h0_0000_0000_0001, 49'h0_0000_0000_0000,
      49'h1_5555_5555_5555, 49'h0_FFFF_8000_0000, 49'h1_FFFF_FFFF_FFFF, 49'h0_F0F0_F0F0_F0F0};

   csa_resolve_pipe dut (
      .Clk_CI      (clock),
      .Rst_RI      (reset),
      .Flush_SI    (flush),
      .InValid_SI  (inValid),
      .InReady_SO  (inReady),
      .Sum_DI      (sumIn),
      .Carry_DI    (carryIn),
      .Tag_DI      (tagIn),
      .OutValid_SO (outValid),
      .OutReady_SI (outReady),
      .Result_DO   (result),
      .Zero_SO     (zero),
      .Tag_DO      (tagOut)
   );

   // free-running 100 MHz clock
   always #5 clock = ~clock;

   // the exact value a carry-save pair stands for
   function automatic logic [50:0] modelSum(input logic [48:0] s, input logic [48:0] c);
      return {2'b00, s} + {1'b0, c, 1'b0};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // push a few throwaway pairs on consecutive cycles
   task automatic applyStimulus(input int count, input logic [3:0] baseTag);
      for (int i = 0; i < count; i++) begin
         @(negedge clock);
         inValid = 1'b1;
         sumIn   = 49'h1000 + 49'(i);
         carryIn = 49'(i);
         tagIn   = baseTag + 4'(i);
      end
   endtask

   // one pair through an empty pipe: nothing at 3 cycles, result at 4 cycles
   task automatic runSingle(input string name, input logic [48:0] s, input logic [48:0] c,
                            input logic [3:0] t, input logic [50:0] expRes);
      @(negedge clock);
      outReady = 1'b1;
      sumIn    = s;
      carryIn  = c;
      tagIn    = t;
      inValid  = 1'b1;
      #1 checkOutput({name, "_inready"}, 64'(inReady), 64'd1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         inValid = 1'b0;
         #1;
         if (i == 3) checkOutput({name, "_early"}, 64'(outValid), 64'd0);
      end
      checkOutput({name, "_valid"}, 64'(outValid), 64'd1);
      checkOutput({name, "_result"}, 64'(result), 64'(expRes));
      checkOutput({name, "_zero"}, 64'(zero), (expRes == 51'd0) ? 64'd1 : 64'd0);
      checkOutput({name, "_tag"}, 64'(tagOut), 64'(t));
   endtask

   // guard against a hung handshake
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // main directed sequence
   initial begin
      int          idxIn;
      int          idxOut;
      logic        stall;
      logic [50:0] holdRes;
      logic [3:0]  holdTag;

      reset    = 1'b1;
      flush    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b0;
      sumIn    = '0;
      carryIn  = '0;
      tagIn    = '0;
      holdRes  = '0;
      holdTag  = '0;

      @(negedge clock);
      @(negedge clock);
      #1;
      checkOutput("rst_valid", 64'(outValid), 64'd0);
      checkOutput("rst_result", 64'(result), 64'd0);
      checkOutput("rst_zero", 64'(zero), 64'd0);
      checkOutput("rst_tag", 64'(tagOut), 64'd0);
      checkOutput("rst_inready", 64'(inReady), 64'd1);
      reset = 1'b0;

      @(negedge clock);
      #1;
      checkOutput("empty_inready", 64'(inReady), 64'd1);
      checkOutput("empty_valid", 64'(outValid), 64'd0);

      runSingle("one", 49'h1, 49'h0, 4'h3, 51'h1);
      runSingle("seg_carry", 49'hFFFF, 49'h1, 4'h5, 51'h10001);
      runSingle("all_ones", 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 4'hA, 51'h5_FFFF_FFFF_FFFD);
      runSingle("zero", 49'h0, 49'h0, 4'h0, 51'h0);

      // stream of 8 with the consumer stalled for cycles 6..11
      idxIn  = 0;
      idxOut = 0;
      for (int cyc = 0; cyc < 100 && idxOut < 8; cyc++) begin
         @(negedge clock);
         stall    = (cyc >= 6 && cyc < 12);
         outReady = !stall;
         inValid  = (idxIn < 8);
         if (idxIn < 8) begin
            sumIn   = streamSum[idxIn];
            carryIn = streamCarry[idxIn];
            tagIn   = idxIn[3:0];
         end
         #1;
         if (cyc == 6) begin
            holdRes = result;
            holdTag = tagOut;
            checkOutput("stall_valid", 64'(outValid), 64'd1);
         end
         if (stall && cyc > 6) begin
            checkOutput("stall_res_hold", 64'(result), 64'(holdRes));
            checkOutput("stall_tag_hold", 64'(tagOut), 64'(holdTag));
         end
         if (cyc == 11) begin
            checkOutput("full_inready", 64'(inReady), 64'd0);
            checkOutput("full_inflight", 64'(idxIn - idxOut), 64'd4);
         end
         if (outValid && outReady) begin
            checkOutput("stream_result", 64'(result), 64'(modelSum(streamSum[idxOut], streamCarry[idxOut])));
            checkOutput("stream_tag", 64'(tagOut), 64'(idxOut));
            idxOut++;
         end
         if (inValid && inReady) idxIn++;
      end
      @(negedge clock);
      inValid = 1'b0;
      #1;
      checkOutput("stream_count", 64'(idxOut), 64'd8);
      checkOutput("stream_no_dup", 64'(outValid), 64'd0);

      // flush with three stages full and a pair offered in the same cycle
      outReady = 1'b1;
      applyStimulus(3, 4'h8);
      @(negedge clock);
      flush   = 1'b1;
      inValid = 1'b1;
      sumIn   = 49'h7;
      tagIn   = 4'hF;
      #1 checkOutput("flush_inready", 64'(inReady), 64'd1);
      @(negedge clock);
      flush   = 1'b0;
      inValid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1 checkOutput("flush_valid", 64'(outValid), 64'd0);
         @(negedge clock);
      end
      runSingle("post_flush", 49'h0_1234_5678_9ABC, 49'h0_0000_1111_2222, 4'h6,
                modelSum(49'h0_1234_5678_9ABC, 49'h0_0000_1111_2222));

      // reset while a result is waiting at the output
      outReady = 1'b0;
      applyStimulus(4, 4'h1);
      @(negedge clock);
      inValid = 1'b0;
      #1 checkOutput("pre_rst_valid", 64'(outValid), 64'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_valid", 64'(outValid), 64'd0);
      checkOutput("midrst_result", 64'(result), 64'd0);
      checkOutput("midrst_tag", 64'(tagOut), 64'd0);
      checkOutput("midrst_zero", 64'(zero), 64'd0);
      @(negedge clock);
      reset    = 1'b0;
      outReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 checkOutput("post_rst_idle", 64'(outValid), 64'd0);
         @(negedge clock);
      end
      runSingle("post_rst", 49'h1_0000_0000_0000, 49'h0_8000_0000_0000, 4'h9,
                modelSum(49'h1_0000_0000_0000, 49'h0_8000_0000_0000));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
